// File: rtl/fifo_reader.sv
// Pop-side controller for a flag-less FIFO: mirrors occupancy from the writer's push,
// stages words into a one-entry valid/ready output register, and supports discard-all flush.
module fifo_reader #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_seen,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_full,
  output logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  input  logic             flush,
  output logic             busy,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             overflow,
  output logic             mismatch
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overflow_q;
  logic             mismatch_q;
  logic             pop_s;
  logic             busy_s;
  logic             acc_push_s;
  logic             at_depth_s;

  assign at_depth_s = (count_q == DEPTH_C);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FLUSH exits on the edge where the mirrored count lands on zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (count_d == ZERO_C) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: pop never looks at push_seen, only at registered state and ready
  always_comb begin
    pop_s  = 1'b0;
    busy_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        pop_s  = !empty_q && (!valid_q || ready);
        busy_s = 1'b0;
      end
      ST_FLUSH: begin
        pop_s  = !empty_q;
        busy_s = 1'b1;
      end
      default: begin
        pop_s  = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  // Occupancy mirror; a push while full only lands if a pop frees the slot this cycle
  always_comb begin
    acc_push_s = push_seen && (!at_depth_s || pop_s);
    if (acc_push_s && !pop_s) begin
      count_d = count_q + ONE_C;
    end else if (pop_s && !acc_push_s) begin
      count_d = count_q - ONE_C;
    end else begin
      count_d = count_q;
    end
  end

  // Counter and empty register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO_C;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == ZERO_C);
    end
  end

  // Output register; words popped during a flush (or on its entry edge) are discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else if (state_q == ST_FLUSH || flush) begin
      valid_q <= 1'b0;
    end else if (pop_s) begin
      data_q  <= fifo_out;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (push_seen && at_depth_s && !pop_s);
      mismatch_q <= mismatch_q | (fifo_full != at_depth_s);
    end
  end

  assign pop      = pop_s;
  assign busy     = busy_s;
  assign data     = data_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small behavioural FIFO attached on the pop side.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_seen;
  logic [1:0] push_data;
  logic [1:0] fifo_out;
  logic       fifo_full;
  logic       pop;
  logic [1:0] data;
  logic       valid;
  logic       ready;
  logic       flush;
  logic       busy;
  logic [2:0] count;
  logic       empty;
  logic       overflow;
  logic       mismatch;

  int vectors = 0;
  int miscompares = 0;

  fifo_reader #(.DEPTH(4), .WIDTH(2)) dut (
    .clk(clk), .reset(reset), .push_seen(push_seen), .fifo_out(fifo_out),
    .fifo_full(fifo_full), .pop(pop), .data(data), .valid(valid), .ready(ready),
    .flush(flush), .busy(busy), .count(count), .empty(empty),
    .overflow(overflow), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural 4-entry FIFO obeying the push-while-full contract
  logic [1:0] mem [4];
  logic [1:0] rp, wp;
  logic [2:0] fcnt;
  logic       m_pop, m_push;
  assign m_pop     = pop && (fcnt != 3'd0);
  assign m_push    = push_seen && ((fcnt != 3'd4) || m_pop);
  assign fifo_out  = mem[rp];
  assign fifo_full = (fcnt == 3'd4);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp   <= 2'd0;
      wp   <= 2'd0;
      fcnt <= 3'd0;
    end else begin
      if (m_push) begin
        mem[wp] <= push_data;
        wp      <= wp + 2'd1;
      end
      if (m_pop) rp <= rp + 2'd1;
      fcnt <= fcnt + {2'b00, m_push} - {2'b00, m_pop};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [1:0] w);
    push_seen = 1'b1;
    push_data = w;
    tick();
    push_seen = 1'b0;
  endtask

  initial begin
    reset = 1'b0; push_seen = 1'b0; push_data = 2'd0; ready = 1'b0; flush = 1'b0;
    repeat (2) tick();
    chk("rst_data", {6'd0, data}, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_count", {5'd0, count}, 8'h00);
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_pop", {7'd0, pop}, 8'h00);
    chk("rst_flags", {6'd0, overflow, mismatch}, 8'h00);
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_pop", {7'd0, pop}, 8'h00);
    chk("idle_empty", {7'd0, empty}, 8'h01);

    // In-order drain: first word lands in the output register, four fill the FIFO
    push_word(2'b01); push_word(2'b10); push_word(2'b11); push_word(2'b01); push_word(2'b10);
    chk("fill_count", {5'd0, count}, 8'h04);
    chk("fill_valid", {7'd0, valid}, 8'h01);
    chk("fill_data", {6'd0, data}, 8'h01);
    chk("fill_mismatch", {7'd0, mismatch}, 8'h00);
    ready = 1'b1;
    #1;
    chk("drain_pop", {7'd0, pop}, 8'h01);
    tick(); chk("drain_d1", {6'd0, data}, 8'h02);
    tick(); chk("drain_d2", {6'd0, data}, 8'h03);
    tick(); chk("drain_d3", {6'd0, data}, 8'h01);
    tick(); chk("drain_d4", {6'd0, data}, 8'h02);
    chk("drain_count", {5'd0, count}, 8'h00);
    tick();
    chk("drain_valid", {7'd0, valid}, 8'h00);
    chk("drain_mismatch", {7'd0, mismatch}, 8'h00);
    ready = 1'b0;

    // Back-pressure
    push_word(2'b10); push_word(2'b11);
    chk("bp_data", {6'd0, data}, 8'h02);
    chk("bp_count", {5'd0, count}, 8'h01);
    tick();
    chk("bp_hold_data", {6'd0, data}, 8'h02);
    chk("bp_hold_valid", {7'd0, valid}, 8'h01);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_rel_data", {6'd0, data}, 8'h03);
    chk("bp_rel_count", {5'd0, count}, 8'h00);

    // Full with simultaneous push and pop
    push_word(2'b01); push_word(2'b10); push_word(2'b11); push_word(2'b01);
    chk("full_count", {5'd0, count}, 8'h04);
    ready = 1'b1; push_seen = 1'b1; push_data = 2'b00;
    #1;
    chk("full_pop", {7'd0, pop}, 8'h01);
    tick();
    push_seen = 1'b0; ready = 1'b0;
    chk("pp_count", {5'd0, count}, 8'h04);
    chk("pp_overflow", {7'd0, overflow}, 8'h00);
    chk("pp_data", {6'd0, data}, 8'h01);

    // Overflow: the dropped 11 must never appear
    push_word(2'b11);
    chk("ovf_flag", {7'd0, overflow}, 8'h01);
    chk("ovf_count", {5'd0, count}, 8'h04);
    ready = 1'b1;
    tick(); chk("ovf_d1", {6'd0, data}, 8'h02);
    tick(); chk("ovf_d2", {6'd0, data}, 8'h03);
    tick(); chk("ovf_d3", {6'd0, data}, 8'h01);
    tick(); chk("ovf_d4", {6'd0, data}, 8'h00);
    tick();
    chk("ovf_valid", {7'd0, valid}, 8'h00);
    chk("ovf_mismatch", {7'd0, mismatch}, 8'h00);
    ready = 1'b0;

    // Flush with three queued words and a pending output word
    push_word(2'b01); push_word(2'b10); push_word(2'b11); push_word(2'b00);
    chk("pre_fl_count", {5'd0, count}, 8'h03);
    chk("pre_fl_valid", {7'd0, valid}, 8'h01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1_busy", {7'd0, busy}, 8'h01);
    chk("fl1_valid", {7'd0, valid}, 8'h00);
    tick();
    chk("fl2_busy", {7'd0, busy}, 8'h01);
    chk("fl2_count", {5'd0, count}, 8'h02);
    tick();
    chk("fl3_busy", {7'd0, busy}, 8'h01);
    chk("fl3_valid", {7'd0, valid}, 8'h00);
    tick();
    chk("fl_end_busy", {7'd0, busy}, 8'h00);
    chk("fl_end_count", {5'd0, count}, 8'h00);
    chk("fl_end_data", {6'd0, data}, 8'h01);
    push_word(2'b10);
    tick();
    chk("post_fl_data", {6'd0, data}, 8'h02);
    chk("post_fl_valid", {7'd0, valid}, 8'h01);
    chk("post_fl_flags", {6'd0, overflow, mismatch}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
